// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bundle: NUM_REQ packed valid/addr/data lanes with a one-hot ready return.
// master = requester side, slave = arbiter side.
interface rf_wb_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 3
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: clears all registers after reset, then round-robin
// arbitrates writeback requesters into one registered write per cycle, dropping writes to x0.
module rf_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    rf_wb_arbiter_if.slave        req_if,
    output logic                  rf_regWrite,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [WORD_WIDTH-1:0] rf_data_in,
    output logic                  init_done
);
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

    typedef enum logic {StClear, StRun} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [PtrW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;

    logic [NUM_REQ-1:0]      grant;
    logic                    grant_vld;
    logic [PtrW-1:0]         grant_idx;
    logic [PtrW-1:0]         cand;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [WORD_WIDTH-1:0]   sel_data;

    // Search starts just after the last winner; ready is gated by rst so nothing is granted in reset.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state_q == StRun && !rst) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
                if (!grant_vld && req_if.req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_vld) grant[grant_idx] = 1'b1;
        end
    end

    assign sel_addr = req_if.req_addr[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = req_if.req_data[32'(grant_idx) * WORD_WIDTH +: WORD_WIDTH];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q;
        unique case (state_q)
            StClear: begin
                we_d      = 1'b1;
                addr_d    = clr_cnt_q;
                data_d    = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastAddr) begin
                    state_d = StRun;
                    done_d  = 1'b1;
                end
            end
            StRun: begin
                if (grant_vld) begin
                    rr_ptr_d = grant_idx;
                    // x0 is hardwired zero: accept the request but suppress the write.
                    we_d     = (sel_addr != '0);
                    addr_d   = sel_addr;
                    data_d   = sel_data;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            rr_ptr_q  <= PtrW'(NUM_REQ - 1);
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign req_if.req_ready = grant;
    assign rf_regWrite      = we_q;
    assign rf_write_addr    = addr_q;
    assign rf_data_in       = data_q;
    assign init_done        = done_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a reference model predicts ready each cycle and pushes the
// expected registered write into a queue, popped and compared after the following clock edge.
module tb_rf_wb_arbiter;
    localparam int unsigned AW = 5;
    localparam int unsigned WW = 32;
    localparam int unsigned NR = 3;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic          done;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [WW-1:0] rf_data;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference model state
    bit            m_run;
    int            m_cnt;
    int            m_rr;
    logic [AW-1:0] m_addr;
    logic [WW-1:0] m_data;
    logic          m_done;

    rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .NUM_REQ(NR)) req_if ();

    rf_wb_arbiter #(
        .ADDR_WIDTH(AW),
        .WORD_WIDTH(WW),
        .NUM_REQ   (NR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_if       (req_if.slave),
        .rf_regWrite  (rf_we),
        .rf_write_addr(rf_addr),
        .rf_data_in   (rf_data),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] a,
                           input logic [WW-1:0] d);
        req_if.req_valid[i]        = v;
        req_if.req_addr[i*AW +: AW] = a;
        req_if.req_data[i*WW +: WW] = d;
    endtask

    task automatic out_is(input string tag, input logic we, input logic [AW-1:0] a,
                          input logic [WW-1:0] d);
        chk({tag, "_we"}, 32'(rf_we), 32'(we));
        chk({tag, "_addr"}, 32'(rf_addr), 32'(a));
        chk({tag, "_data"}, rf_data, d);
    endtask

    // One clock: check ready at the falling edge, then check registered outputs after the rise.
    task automatic cyc(input bit use_want = 1'b0, input logic [NR-1:0] want = '0);
        exp_t          e;
        int            g;
        logic [NR-1:0] er;
        logic [AW-1:0] a;
        @(negedge clk);
        g  = -1;
        er = '0;
        if (!rst && m_run) begin
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && req_if.req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_if.req_ready), 32'(er));
        if (use_want) chk("req_ready_dir", 32'(req_if.req_ready), 32'(want));

        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_rr = NR - 1;
            m_addr = '0; m_data = '0; m_done = 1'b0;
            e = '{we: 1'b0, addr: '0, data: '0, done: 1'b0};
        end else if (!m_run) begin
            m_addr = AW'(m_cnt);
            m_data = '0;
            if (m_cnt == (1 << AW) - 1) begin
                m_run  = 1'b1;
                m_done = 1'b1;
            end
            m_cnt = (m_cnt + 1) % (1 << AW);
            e = '{we: 1'b1, addr: m_addr, data: '0, done: m_done};
        end else if (g >= 0) begin
            a      = req_if.req_addr[g*AW +: AW];
            m_rr   = g;
            m_addr = a;
            m_data = req_if.req_data[g*WW +: WW];
            e = '{we: (a != '0), addr: a, data: m_data, done: m_done};
        end else begin
            e = '{we: 1'b0, addr: m_addr, data: m_data, done: m_done};
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("rf_regWrite", 32'(rf_we), 32'(e.we));
        chk("rf_write_addr", 32'(rf_addr), 32'(e.addr));
        chk("rf_data_in", rf_data, e.data);
        chk("init_done", 32'(init_done), 32'(e.done));
    endtask

    initial begin
        rst = 1'b1;
        req_if.req_valid = '0;
        req_if.req_addr  = '0;
        req_if.req_data  = '0;
        m_run = 1'b0; m_cnt = 0; m_rr = NR - 1;
        m_addr = '0; m_data = '0; m_done = 1'b0;

        // Reset, then full clear sequence with no requests
        cyc(1'b1, 3'b000);
        out_is("rst", 1'b0, '0, '0);
        cyc(1'b1, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 3'b000);
            out_is("clr", 1'b1, AW'(i), '0);
            chk("clr_done", 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
        end
        cyc(1'b1, 3'b000);
        chk("idle_we", 32'(rf_we), 32'd0);
        chk("idle_done", 32'(init_done), 32'd1);

        // Single request from req1
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        cyc(1'b1, 3'b010);
        set_req(1, 1'b0, '0, '0);
        out_is("t2", 1'b1, 5'd5, 32'hDEAD_BEEF);

        // Write to x0 is accepted but dropped
        set_req(0, 1'b1, 5'd0, 32'h0000_1234);
        cyc(1'b1, 3'b001);
        chk("x0_we", 32'(rf_we), 32'd0);
        // rr_ptr now 0, so req1 beats req0, then req0 wins next
        set_req(0, 1'b1, 5'd3, 32'h0000_0033);
        set_req(1, 1'b1, 5'd9, 32'h0000_0099);
        cyc(1'b1, 3'b010);
        out_is("after_x0", 1'b1, 5'd9, 32'h0000_0099);
        set_req(1, 1'b0, '0, '0);
        cyc(1'b1, 3'b001);
        out_is("req0_next", 1'b1, 5'd3, 32'h0000_0033);
        set_req(0, 1'b0, '0, '0);

        // Move rr_ptr to 2, then all three continuously valid
        set_req(2, 1'b1, 5'd20, 32'h0000_0200);
        cyc(1'b1, 3'b100);
        set_req(0, 1'b1, 5'd10, 32'hA000_0000);
        set_req(1, 1'b1, 5'd11, 32'hA000_0001);
        set_req(2, 1'b1, 5'd12, 32'hA000_0002);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, NR'(1 << (i % 3)));
            out_is("rr", 1'b1, AW'(10 + i % 3), 32'hA000_0000 + 32'(i % 3));
        end
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 3'b100);
            out_is("req2_only", 1'b1, 5'd12, 32'hA000_0002);
        end
        set_req(2, 1'b0, '0, '0);
        cyc(1'b1, 3'b000);
        chk("hold_addr", 32'(rf_addr), 32'd12);

        // Reset mid-clear at address 10
        rst = 1'b1;
        cyc(1'b1, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc(1'b1, 3'b000);
        chk("pre_rst_addr", 32'(rf_addr), 32'd9);
        rst = 1'b1;
        cyc(1'b1, 3'b000);
        chk("midrst_we", 32'(rf_we), 32'd0);
        chk("midrst_done", 32'(init_done), 32'd0);
        rst = 1'b0;

        // req0 held from the first cycle after reset
        set_req(0, 1'b1, 5'd7, 32'h0000_0077);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 3'b000);
            out_is("clr2", 1'b1, AW'(i), '0);
        end
        cyc(1'b1, 3'b001);
        out_is("first_run", 1'b1, 5'd7, 32'h0000_0077);
        set_req(0, 1'b0, '0, '0);
        cyc(1'b1, 3'b000);
        chk("final_we", 32'(rf_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
